// File: rtl/aes_pkg.sv
// Shared constants for the AES-128 round controller: one-hot state encoding,
// round count, round-constant seed/polynomial and the xtime helper.
package aes_pkg;

    localparam int         AES128_NR = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    localparam int         ST_W      = 7;
    localparam logic [ST_W-1:0] ST_IDLE   = 7'b000_0001;
    localparam logic [ST_W-1:0] ST_INIT   = 7'b000_0010;
    localparam logic [ST_W-1:0] ST_KEXP   = 7'b000_0100;
    localparam logic [ST_W-1:0] ST_SUB    = 7'b000_1000;
    localparam logic [ST_W-1:0] ST_MIXARK = 7'b001_0000;
    localparam logic [ST_W-1:0] ST_DONE   = 7'b010_0000;
    localparam logic [ST_W-1:0] ST_HOLD   = 7'b100_0000;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = ST_IDLE,
        S_INIT   = ST_INIT,
        S_KEXP   = ST_KEXP,
        S_SUB    = ST_SUB,
        S_MIXARK = ST_MIXARK,
        S_DONE   = ST_DONE,
        S_HOLD   = ST_HOLD
    } state_t;

    // GF(2^8) multiply by x, reduced by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: synchronous re-seed to RCON_INIT, xtime on step.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       init,
    input  logic       step,
    output logic [7:0] rcon
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rcon <= RCON_INIT;
        end else if (init) begin
            rcon <= RCON_INIT;
        end else if (step) begin
            rcon <= xtime(rcon);
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: Moore FSM driving the round datapath,
// time-multiplexing the shared S-box between key expansion and SubBytes.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR     = AES128_NR,
    parameter int SB_LAT = 1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    output logic       ld_state,
    output logic       ld_key,
    output logic       sbox_sel,
    output logic       kexp_en,
    output logic       sub_en,
    output logic       shift_en,
    output logic       mix_en,
    output logic       ark_en,
    output logic [3:0] round,
    output logic [7:0] rcon,
    output logic       busy,
    output logic       finished
);

    localparam int             CNT_W    = (SB_LAT > 1) ? $clog2(SB_LAT) : 1;
    localparam logic [CNT_W-1:0] SUB_LAST = CNT_W'(SB_LAT - 1);
    localparam logic [3:0]     NR_R     = 4'(NR);

    state_t           state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic [CNT_W-1:0] sub_cnt_q, sub_cnt_d;
    logic             rcon_init, rcon_step;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            round_q   <= '0;
            sub_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            sub_cnt_q <= sub_cnt_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        sub_cnt_d = '0;
        rcon_init = 1'b0;
        rcon_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_KEXP;
                    round_d   = 4'd1;
                    rcon_init = 1'b1;
                end
            end
            S_KEXP: begin
                state_d = start ? S_SUB : S_IDLE;
            end
            S_SUB: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (sub_cnt_q == SUB_LAST) begin
                    state_d = S_MIXARK;
                end else begin
                    sub_cnt_d = sub_cnt_q + CNT_W'(1);
                end
            end
            S_MIXARK: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (round_q == NR_R) begin
                    state_d = S_DONE;
                end else begin
                    state_d   = S_KEXP;
                    round_d   = round_q + 4'd1;
                    rcon_step = 1'b1;
                end
            end
            S_DONE: begin
                state_d = start ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!start) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any entry into (or stay in) IDLE restores the idle round/rcon values.
        if (state_d == S_IDLE) begin
            round_d   = '0;
            rcon_init = 1'b1;
            rcon_step = 1'b0;
        end
    end

    aes_rcon_gen u_rcon (
        .clk  (clk),
        .nrst (nrst),
        .init (rcon_init),
        .step (rcon_step),
        .rcon (rcon)
    );

    always_comb begin
        ld_state = 1'b0;
        ld_key   = 1'b0;
        sbox_sel = 1'b0;
        kexp_en  = 1'b0;
        sub_en   = 1'b0;
        shift_en = 1'b0;
        mix_en   = 1'b0;
        ark_en   = 1'b0;
        busy     = 1'b0;
        finished = 1'b0;
        case (state_q)
            S_INIT: begin
                ld_state = 1'b1;
                ld_key   = 1'b1;
                ark_en   = 1'b1;
                busy     = 1'b1;
            end
            S_KEXP: begin
                sbox_sel = 1'b1;
                kexp_en  = 1'b1;
                busy     = 1'b1;
            end
            S_SUB: begin
                sub_en = (sub_cnt_q == SUB_LAST);
                busy   = 1'b1;
            end
            S_MIXARK: begin
                shift_en = 1'b1;
                ark_en   = 1'b1;
                mix_en   = (round_q != NR_R);
                busy     = 1'b1;
            end
            S_DONE: begin
                finished = 1'b1;
            end
            default: ;
        endcase
    end

    assign round = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed self-checking bench for aes_round_ctrl: default and SB_LAT=3
// instances, hold, abort, async reset and single-cycle start cases.
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic nrst;
    logic start0, start1;

    logic       ld_state0, ld_key0, sbox_sel0, kexp_en0, sub_en0, shift_en0, mix_en0, ark_en0;
    logic [3:0] round0;
    logic [7:0] rcon0;
    logic       busy0, finished0;

    logic       ld_state1, ld_key1, sbox_sel1, kexp_en1, sub_en1, shift_en1, mix_en1, ark_en1;
    logic [3:0] round1;
    logic [7:0] rcon1;
    logic       busy1, finished1;

    logic [7:0] strb0, strb1;
    assign strb0 = {ld_state0, ld_key0, sbox_sel0, kexp_en0, sub_en0, shift_en0, mix_en0, ark_en0};
    assign strb1 = {ld_state1, ld_key1, sbox_sel1, kexp_en1, sub_en1, shift_en1, mix_en1, ark_en1};

    always #5 clk = ~clk;

    aes_round_ctrl u0 (
        .clk(clk), .nrst(nrst), .start(start0),
        .ld_state(ld_state0), .ld_key(ld_key0), .sbox_sel(sbox_sel0), .kexp_en(kexp_en0),
        .sub_en(sub_en0), .shift_en(shift_en0), .mix_en(mix_en0), .ark_en(ark_en0),
        .round(round0), .rcon(rcon0), .busy(busy0), .finished(finished0)
    );

    aes_round_ctrl #(.NR(10), .SB_LAT(3)) u1 (
        .clk(clk), .nrst(nrst), .start(start1),
        .ld_state(ld_state1), .ld_key(ld_key1), .sbox_sel(sbox_sel1), .kexp_en(kexp_en1),
        .sub_en(sub_en1), .shift_en(shift_en1), .mix_en(mix_en1), .ark_en(ark_en1),
        .round(round1), .rcon(rcon1), .busy(busy1), .finished(finished1)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int fin;
        int subs;
        int n;
        int p;
        int r;
        bit found;

        nrst   = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_round", 32'(round0), 32'd0);
        check("rst_rcon", 32'(rcon0), 32'h01);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_finished", 32'(finished0), 32'd0);
        check("rst_strobes", 32'(strb0), 32'd0);
        nrst = 1'b1;
        @(negedge clk);

        // SB_LAT=3: rounds are 5 cycles, finished in cycle 52
        start1 = 1'b1;
        subs   = 0;
        for (int c = 1; c <= 54; c++) begin
            @(negedge clk);
            p = c - 2;
            check("lat3_sub_en", 32'(sub_en1), 32'((c >= 2 && c <= 51 && p % 5 == 3) ? 1 : 0));
            check("lat3_sbox_sel", 32'(sbox_sel1), 32'((c >= 2 && c <= 51 && p % 5 == 0) ? 1 : 0));
            check("lat3_finished", 32'(finished1), 32'((c == 52) ? 1 : 0));
            if (sub_en1) subs++;
        end
        check("lat3_sub_count", 32'(subs), 32'd10);
        start1 = 1'b0;
        @(negedge clk);
        check("lat3_idle_round", 32'(round1), 32'd0);
        check("lat3_idle_busy", 32'(busy1), 32'd0);

        // Default run with start held high
        start0 = 1'b1;
        fin    = 0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (c == 1) check("init_loads", 32'({ld_state0, ld_key0, ark_en0}), 32'b111);
            check("def_busy", 32'(busy0), 32'((c <= 31) ? 1 : 0));
            check("def_finished", 32'(finished0), 32'((c == 32) ? 1 : 0));
            if (finished0) fin++;
            p = c - 2;
            r = p / 3 + 1;
            if (c >= 2 && c <= 31) begin
                if (p % 3 == 0) begin
                    check("kexp_rcon", 32'(rcon0), 32'(rcon_tab[r-1]));
                    check("kexp_round", 32'(round0), 32'(r));
                    check("kexp_en", 32'({sbox_sel0, kexp_en0}), 32'b11);
                end
                if (p % 3 == 2) begin
                    check("mixark_mix_en", 32'(mix_en0), 32'((r != 10) ? 1 : 0));
                    check("mixark_ark_en", 32'({shift_en0, ark_en0}), 32'b11);
                end
            end
        end
        check("def_finished_count", 32'(fin), 32'd1);

        // Held start: HOLD with no strobes, no re-trigger
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_strobes", 32'({strb0, busy0, finished0}), 32'd0);
        end
        start0 = 1'b0;
        @(negedge clk);
        check("hold_exit_round", 32'(round0), 32'd0);
        check("hold_exit_busy", 32'(busy0), 32'd0);
        start0 = 1'b1;
        @(negedge clk);
        check("restart_init", 32'(ld_state0), 32'd1);

        // Abort in SUB of round 4 (cycle 12)
        repeat (11) @(negedge clk);
        check("abort_pre_sub_en", 32'(sub_en0), 32'd1);
        check("abort_pre_round", 32'(round0), 32'd4);
        check("abort_pre_rcon", 32'(rcon0), 32'h08);
        start0 = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_round", 32'(round0), 32'd0);
        check("abort_rcon", 32'(rcon0), 32'h01);
        check("abort_strobes", 32'(strb0), 32'd0);
        fin = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (finished0) fin++;
        end
        check("abort_no_finished", 32'(fin), 32'd0);

        // Async reset in round 6 MIXARK (cycle 19)
        start0 = 1'b1;
        @(negedge clk);
        repeat (18) @(negedge clk);
        check("rst6_round", 32'(round0), 32'd6);
        check("rst6_mixark", 32'({shift_en0, ark_en0, mix_en0}), 32'b111);
        #2 nrst = 1'b0;
        #1;
        check("arst_round", 32'(round0), 32'd0);
        check("arst_rcon", 32'(rcon0), 32'h01);
        check("arst_outs", 32'({strb0, busy0, finished0}), 32'd0);
        @(negedge clk);
        nrst  = 1'b1;
        n     = 0;
        found = 1'b0;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(negedge clk);
            if (finished0) begin
                found = 1'b1;
                n     = i;
            end
        end
        check("post_rst_latency", 32'(n), 32'd32);
        start0 = 1'b0;
        @(negedge clk);

        // Single-cycle start pulse
        start0 = 1'b1;
        @(negedge clk);
        check("pulse_init", 32'(ld_state0), 32'd1);
        start0 = 1'b0;
        @(negedge clk);
        check("pulse_idle_busy", 32'(busy0), 32'd0);
        check("pulse_idle_round", 32'(round0), 32'd0);
        fin = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (finished0) fin++;
        end
        check("pulse_no_finished", 32'(fin), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
